// File: rtl/morse_to_ascii_decoder.sv
// -----------------------------------------------------------------------------
// morse_to_ascii_decoder
//
// Purpose:
//   Times a single debounced Morse key line. Each mark is classified as a dot
//   or a dash, and the gap that ends a character is detected. The captured
//   element sequence (up to 5 elements) is then looked up in the international
//   Morse table (A-Z, 0-9). The block emits the ASCII code or flags an error.
//
// Parameters:
//   CLKS_PER_UNIT  clock cycles per Morse time unit (dot length), >= 2
//   CNT_W          timing counter width, must hold 7*CLKS_PER_UNIT
//
// Ports:
//   i_Clk     system clock, rising edge
//   i_Rst_n   synchronous reset, active-low
//   i_Key     key level (1 = pressed), synchronised and debounced upstream
//   o_ASCII   last decoded character, held until the next emission
//   o_Valid   one-cycle strobe: o_ASCII carries a newly decoded character
//   o_Error   one-cycle strobe: character undecodable (no match or >5 elements)
//   o_Busy    high whenever the FSM is not IDLE
//
// Output handshake:
//   o_Valid and o_Error are push-only strobes with no ready/back-pressure.
//   Each strobe is high for exactly one cycle per character. The two strobes
//   are never high together. The sink must accept the data in that cycle.
//
// Optional feature (compile-time macro MORSE_WORD_SPACE_EN):
//   When defined, a WORD state keeps timing the gap after a character. A gap
//   of 7 units emits one ASCII space (8'h20). When undefined, there is no
//   WORD state and 8'h20 is never produced.
//
// Debug visibility:
//   The FSM state is held in state_q, which has type state_t.
// -----------------------------------------------------------------------------
module morse_to_ascii_decoder #(
  parameter int CLKS_PER_UNIT = 1000,
  parameter int CNT_W         = 16
) (
  input  logic       i_Clk,
  input  logic       i_Rst_n,
  input  logic       i_Key,
  output logic [7:0] o_ASCII,
  output logic       o_Valid,
  output logic       o_Error,
  output logic       o_Busy
);

  localparam logic [CNT_W-1:0] DASH_TH  = CNT_W'(2 * CLKS_PER_UNIT);
  localparam logic [CNT_W-1:0] CHAR_GAP = CNT_W'(3 * CLKS_PER_UNIT);
`ifdef MORSE_WORD_SPACE_EN
  localparam logic [CNT_W-1:0] WORD_GAP = CNT_W'(7 * CLKS_PER_UNIT);
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_MARK,
    S_GAP,
    S_EMIT
`ifdef MORSE_WORD_SPACE_EN
    , S_WORD
`endif
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [4:0]       pat_q,   pat_d;    // element k in bit k, 1 = dash
  logic [2:0]       len_q,   len_d;
  logic             ovf_q,   ovf_d;
  logic [7:0]       ascii_q, ascii_d;
  logic             valid_q, valid_d;
  logic             error_q, error_d;

  logic             elem_dash;
  logic [8:0]       lookup_res;        // {match, code}

  // Saturating increment: the counter holds at all-ones and never wraps.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  // International Morse lookup. The pattern is written MSB first, so the
  // literal bits read last element ... first element.
  function automatic logic [8:0] morse_lookup(input logic [2:0] len,
                                              input logic [4:0] pat);
    logic [8:0] r;
    r = 9'h000;
    case ({len, pat})
      {3'd1, 5'b00000}: r = {1'b1, 8'h45}; // E .
      {3'd1, 5'b00001}: r = {1'b1, 8'h54}; // T -
      {3'd2, 5'b00010}: r = {1'b1, 8'h41}; // A .-
      {3'd2, 5'b00000}: r = {1'b1, 8'h49}; // I ..
      {3'd2, 5'b00011}: r = {1'b1, 8'h4D}; // M --
      {3'd2, 5'b00001}: r = {1'b1, 8'h4E}; // N -.
      {3'd3, 5'b00001}: r = {1'b1, 8'h44}; // D -..
      {3'd3, 5'b00011}: r = {1'b1, 8'h47}; // G --.
      {3'd3, 5'b00101}: r = {1'b1, 8'h4B}; // K -.-
      {3'd3, 5'b00111}: r = {1'b1, 8'h4F}; // O ---
      {3'd3, 5'b00010}: r = {1'b1, 8'h52}; // R .-.
      {3'd3, 5'b00000}: r = {1'b1, 8'h53}; // S ...
      {3'd3, 5'b00100}: r = {1'b1, 8'h55}; // U ..-
      {3'd3, 5'b00110}: r = {1'b1, 8'h57}; // W .--
      {3'd4, 5'b00001}: r = {1'b1, 8'h42}; // B -...
      {3'd4, 5'b00101}: r = {1'b1, 8'h43}; // C -.-.
      {3'd4, 5'b00100}: r = {1'b1, 8'h46}; // F ..-.
      {3'd4, 5'b00000}: r = {1'b1, 8'h48}; // H ....
      {3'd4, 5'b01110}: r = {1'b1, 8'h4A}; // J .---
      {3'd4, 5'b00010}: r = {1'b1, 8'h4C}; // L .-..
      {3'd4, 5'b00110}: r = {1'b1, 8'h50}; // P .--.
      {3'd4, 5'b01011}: r = {1'b1, 8'h51}; // Q --.-
      {3'd4, 5'b01000}: r = {1'b1, 8'h56}; // V ...-
      {3'd4, 5'b01001}: r = {1'b1, 8'h58}; // X -..-
      {3'd4, 5'b01101}: r = {1'b1, 8'h59}; // Y -.--
      {3'd4, 5'b00011}: r = {1'b1, 8'h5A}; // Z --..
      {3'd5, 5'b11111}: r = {1'b1, 8'h30}; // 0 -----
      {3'd5, 5'b11110}: r = {1'b1, 8'h31}; // 1 .----
      {3'd5, 5'b11100}: r = {1'b1, 8'h32}; // 2 ..---
      {3'd5, 5'b11000}: r = {1'b1, 8'h33}; // 3 ...--
      {3'd5, 5'b10000}: r = {1'b1, 8'h34}; // 4 ....-
      {3'd5, 5'b00000}: r = {1'b1, 8'h35}; // 5 .....
      {3'd5, 5'b00001}: r = {1'b1, 8'h36}; // 6 -....
      {3'd5, 5'b00011}: r = {1'b1, 8'h37}; // 7 --...
      {3'd5, 5'b00111}: r = {1'b1, 8'h38}; // 8 ---..
      {3'd5, 5'b01111}: r = {1'b1, 8'h39}; // 9 ----.
      default:          r = 9'h000;
    endcase
    return r;
  endfunction

  assign elem_dash  = (cnt_q >= DASH_TH);
  assign lookup_res = morse_lookup(len_q, pat_q);

  // ---------------------------------------------------------------------------
  // State register (also holds the counter, the element buffer and the
  // registered outputs)
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      pat_q   <= '0;
      len_q   <= '0;
      ovf_q   <= 1'b0;
      ascii_q <= 8'h00;
      valid_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      ovf_q   <= ovf_d;
      ascii_q <= ascii_d;
      valid_q <= valid_d;
      error_q <= error_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pat_d   = pat_q;
    len_d   = len_q;
    ovf_d   = ovf_q;
    ascii_d = ascii_q;
    valid_d = 1'b0;
    error_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (i_Key) begin
          state_d = S_MARK;
          cnt_d   = CNT_W'(1);
        end
      end

      S_MARK: begin
        if (i_Key) begin
          cnt_d = sat_inc(cnt_q);
        end else begin
          // Release: classify the mark from its length so far.
          if (len_q < 3'd5) begin
            pat_d = pat_q | (5'(elem_dash) << len_q);
            len_d = len_q + 3'd1;
          end else begin
            ovf_d = 1'b1;
          end
          state_d = S_GAP;
          cnt_d   = CNT_W'(1);
        end
      end

      S_GAP: begin
        if (i_Key) begin
          state_d = S_MARK;
          cnt_d   = CNT_W'(1);
        end else if (cnt_q == CHAR_GAP - 1'b1) begin
          // This edge is the CHAR_GAP-th low sample. The strobe is
          // registered one edge later, when EMIT completes.
          state_d = S_EMIT;
          cnt_d   = CHAR_GAP;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end

      S_EMIT: begin
        if (lookup_res[8] && !ovf_q) begin
          valid_d = 1'b1;
          ascii_d = lookup_res[7:0];
        end else begin
          error_d = 1'b1;
        end
        pat_d = '0;
        len_d = '0;
        ovf_d = 1'b0;
        // A press sampled here starts the next character without losing a cycle.
        if (i_Key) begin
          state_d = S_MARK;
          cnt_d   = CNT_W'(1);
        end else begin
`ifdef MORSE_WORD_SPACE_EN
          state_d = S_WORD;
          cnt_d   = sat_inc(cnt_q);
`else
          state_d = S_IDLE;
          cnt_d   = '0;
`endif
        end
      end

`ifdef MORSE_WORD_SPACE_EN
      S_WORD: begin
        if (i_Key) begin
          state_d = S_MARK;
          cnt_d   = CNT_W'(1);
        end else if (cnt_q == WORD_GAP - 1'b1) begin
          // Going to IDLE ensures only one space per gap, however long.
          valid_d = 1'b1;
          ascii_d = 8'h20;
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
`endif

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        pat_d   = '0;
        len_d   = '0;
        ovf_d   = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    o_ASCII = ascii_q;
    o_Valid = valid_q;
    o_Error = error_q;
    o_Busy  = (state_q != S_IDLE);
  end

endmodule

// File: tb/tb_morse_to_ascii_decoder.sv
// -----------------------------------------------------------------------------
// tb_morse_to_ascii_decoder
//
// Directed testbench for morse_to_ascii_decoder with CLKS_PER_UNIT=4.
// With this value a dot is 4 cycles, the dash threshold is 8 cycles, the
// character gap is 12 cycles and the word gap is 28 cycles.
//
// Inputs change 1 ns after a rising edge. A monitor samples the outputs on the
// falling edge and collects every o_Valid character and o_Error pulse.
// -----------------------------------------------------------------------------
module tb_morse_to_ascii_decoder;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key = 1'b0;
  logic [7:0] ascii;
  logic       valid;
  logic       error;
  logic       busy;

  always #5 clk = ~clk;

  morse_to_ascii_decoder #(
    .CLKS_PER_UNIT(4),
    .CNT_W        (16)
  ) dut (
    .i_Clk  (clk),
    .i_Rst_n(rst_n),
    .i_Key  (key),
    .o_ASCII(ascii),
    .o_Valid(valid),
    .o_Error(error),
    .o_Busy (busy)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  // ---------------------------------------------------------------------------
  // Scoreboard: observed strobes, compared against hand-computed expectations
  // ---------------------------------------------------------------------------
  logic [7:0] got_q[$];
  int         err_cnt  = 0;
  int         both_cnt = 0;

  always @(negedge clk) begin
    if (valid) got_q.push_back(ascii);
    if (error) err_cnt++;
    if (valid && error) both_cnt++;
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  // Hold the key at 'level' so that exactly n rising edges sample it.
  task automatic key_cycles(input logic level, input int n);
    key = level;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_sb();
    got_q.delete();
    err_cnt = 0;
  endtask

  // Send one character from a "-." string, then a 20-cycle gap
  // (longer than the character gap, shorter than the word gap).
  task automatic send_code(input string s);
    for (int i = 0; i < s.len(); i++) begin
      key_cycles(1'b1, (s[i] == "-") ? 12 : 4);
      key_cycles(1'b0, (i == s.len() - 1) ? 20 : 4);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst_n = 1'b0;
    key   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if ({ascii, valid, error, busy} !== 11'h000) begin
      tests_failed++;
      $display("FAIL reset_outputs: got ascii=%h v=%b e=%b b=%b, expected all 0",
               ascii, valid, error, busy);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_char_a();
    clear_sb();
    key_cycles(1'b1, 4);
    key_cycles(1'b0, 4);
    key_cycles(1'b1, 12);
    key_cycles(1'b0, 20);
    tests_run++;
    if (got_q.size() !== 1) begin
      tests_failed++;
      $display("FAIL a_count: got %0d strobes, expected 1", got_q.size());
    end
    tests_run++;
    if ((got_q.size() > 0 ? got_q[0] : 8'hxx) !== 8'h41) begin
      tests_failed++;
      $display("FAIL a_code: got %h, expected 41", got_q.size() > 0 ? got_q[0] : 8'hxx);
    end
    tests_run++;
    if (err_cnt !== 0) begin
      tests_failed++;
      $display("FAIL a_error: got %0d errors, expected 0", err_cnt);
    end
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL a_busy_after: got %b, expected 0", busy);
    end
  endtask

  task automatic test_threshold();
    clear_sb();
    key_cycles(1'b1, 7);
    key_cycles(1'b0, 20);
    key_cycles(1'b1, 8);
    key_cycles(1'b0, 20);
    tests_run++;
    if (got_q.size() !== 2) begin
      tests_failed++;
      $display("FAIL thr_count: got %0d strobes, expected 2", got_q.size());
    end
    tests_run++;
    if ((got_q.size() > 0 ? got_q[0] : 8'hxx) !== 8'h45) begin
      tests_failed++;
      $display("FAIL thr_7_is_E: got %h, expected 45", got_q.size() > 0 ? got_q[0] : 8'hxx);
    end
    tests_run++;
    if ((got_q.size() > 1 ? got_q[1] : 8'hxx) !== 8'h54) begin
      tests_failed++;
      $display("FAIL thr_8_is_T: got %h, expected 54", got_q.size() > 1 ? got_q[1] : 8'hxx);
    end
  endtask

  // After the release, the strobe must appear after the 13th edge, not before.
  task automatic test_latency();
    key_cycles(1'b1, 4);
    key = 1'b0;
    for (int e = 1; e <= 14; e++) begin
      @(posedge clk);
      @(negedge clk);
      if (e == 12) begin
        tests_run++;
        if ({valid, busy} !== 2'b01) begin
          tests_failed++;
          $display("FAIL lat_edge12: got v=%b b=%b, expected v=0 b=1", valid, busy);
        end
      end
      if (e == 13) begin
        tests_run++;
        if ({valid, ascii, busy} !== {1'b1, 8'h45, 1'b0}) begin
          tests_failed++;
          $display("FAIL lat_edge13: got v=%b ascii=%h b=%b, expected v=1 ascii=45 b=0",
                   valid, ascii, busy);
        end
      end
      if (e == 14) begin
        tests_run++;
        if (valid !== 1'b0) begin
          tests_failed++;
          $display("FAIL lat_edge14: got v=%b, expected 0 (one-cycle strobe)", valid);
        end
      end
    end
    key_cycles(1'b0, 10);
  endtask

  task automatic test_gap_boundary();
    // An 11-cycle gap keeps both dots in one character: I.
    clear_sb();
    key_cycles(1'b1, 4);
    key_cycles(1'b0, 11);
    key_cycles(1'b1, 4);
    key_cycles(1'b0, 20);
    tests_run++;
    if (got_q.size() !== 1 || got_q[0] !== 8'h49) begin
      tests_failed++;
      $display("FAIL gap11_I: got %0d strobes first=%h, expected 1 x 49",
               got_q.size(), got_q.size() > 0 ? got_q[0] : 8'hxx);
    end
    // A 12-cycle gap ends the character. The press then lands in EMIT: E, E.
    clear_sb();
    key_cycles(1'b1, 4);
    key_cycles(1'b0, 12);
    key_cycles(1'b1, 4);
    key_cycles(1'b0, 20);
    tests_run++;
    if (got_q.size() !== 2 || got_q[0] !== 8'h45 || got_q[1] !== 8'h45) begin
      tests_failed++;
      $display("FAIL gap12_EE: got %0d strobes first=%h, expected 2 x 45",
               got_q.size(), got_q.size() > 0 ? got_q[0] : 8'hxx);
    end
  endtask

  task automatic test_table();
    string      codes[12] = '{"-.-.", "--.-", "--..", "-.--", "-----", ".----",
                              "----.", "--...", "-.-", ".--", ".---", "-..-"};
    logic [7:0] exp_c[12] = '{8'h43, 8'h51, 8'h5A, 8'h59, 8'h30, 8'h31,
                              8'h39, 8'h37, 8'h4B, 8'h57, 8'h4A, 8'h58};
    for (int i = 0; i < 12; i++) begin
      clear_sb();
      send_code(codes[i]);
      tests_run++;
      if (got_q.size() !== 1 || got_q[0] !== exp_c[i] || err_cnt !== 0) begin
        tests_failed++;
        $display("FAIL table_%s: got %0d strobes first=%h err=%0d, expected 1 x %h",
                 codes[i], got_q.size(), got_q.size() > 0 ? got_q[0] : 8'hxx,
                 err_cnt, exp_c[i]);
      end
    end
  endtask

  task automatic test_errors();
    clear_sb();
    send_code(".....");
    tests_run++;
    if (got_q.size() !== 1 || got_q[0] !== 8'h35) begin
      tests_failed++;
      $display("FAIL five_dots: got %0d strobes first=%h, expected 1 x 35",
               got_q.size(), got_q.size() > 0 ? got_q[0] : 8'hxx);
    end
    clear_sb();
    send_code("......");
    tests_run++;
    if (err_cnt !== 1 || got_q.size() !== 0) begin
      tests_failed++;
      $display("FAIL six_dots: got err=%0d valid=%0d, expected err=1 valid=0",
               err_cnt, got_q.size());
    end
    tests_run++;
    if (ascii !== 8'h35) begin
      tests_failed++;
      $display("FAIL six_dots_hold: got ascii=%h, expected 35", ascii);
    end
    clear_sb();
    send_code("..--");
    tests_run++;
    if (err_cnt !== 1 || got_q.size() !== 0) begin
      tests_failed++;
      $display("FAIL no_code: got err=%0d valid=%0d, expected err=1 valid=0",
               err_cnt, got_q.size());
    end
  endtask

  task automatic test_reset_mid_char();
    clear_sb();
    key_cycles(1'b1, 4);
    key_cycles(1'b0, 4);
    key_cycles(1'b1, 4);
    key_cycles(1'b0, 4);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    tests_run++;
    if ({ascii, valid, error, busy} !== 11'h000) begin
      tests_failed++;
      $display("FAIL midreset_outputs: got ascii=%h v=%b e=%b b=%b, expected all 0",
               ascii, valid, error, busy);
    end
    rst_n = 1'b1;
    key_cycles(1'b1, 12);
    key_cycles(1'b0, 20);
    tests_run++;
    if (got_q.size() !== 1 || got_q[0] !== 8'h54 || err_cnt !== 0) begin
      tests_failed++;
      $display("FAIL midreset_T: got %0d strobes first=%h err=%0d, expected 1 x 54",
               got_q.size(), got_q.size() > 0 ? got_q[0] : 8'hxx, err_cnt);
    end
  endtask

  task automatic test_word_gap();
    clear_sb();
    key_cycles(1'b1, 4);
    key_cycles(1'b0, 60);
`ifdef MORSE_WORD_SPACE_EN
    tests_run++;
    if (got_q.size() !== 2 || got_q[0] !== 8'h45 || got_q[1] !== 8'h20) begin
      tests_failed++;
      $display("FAIL word_space: got %0d strobes first=%h, expected 45 then 20",
               got_q.size(), got_q.size() > 0 ? got_q[0] : 8'hxx);
    end
`else
    tests_run++;
    if (got_q.size() !== 1 || got_q[0] !== 8'h45) begin
      tests_failed++;
      $display("FAIL no_word_space: got %0d strobes first=%h, expected only 45",
               got_q.size(), got_q.size() > 0 ? got_q[0] : 8'hxx);
    end
`endif
  endtask

  task automatic test_exclusive_strobes();
    tests_run++;
    if (both_cnt !== 0) begin
      tests_failed++;
      $display("FAIL strobes_exclusive: got %0d cycles with both high, expected 0",
               both_cnt);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and final report
  // ---------------------------------------------------------------------------
  initial begin
    test_reset();
    test_char_a();
    test_threshold();
    test_latency();
    test_gap_boundary();
    test_table();
    test_errors();
    test_reset_mid_char();
    test_word_gap();
    test_exclusive_strobes();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
